mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 15, maximum consecutive wait cycles for mem_ready before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register; sampled in DECODE only.
REQ-005 mem_ready  input  1  memory completion handshake; high = access done this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 ALUOp, ALUSrcB, PCSource  output  2 each  datapath controls.
REQ-008 state  output  4  current state code, for debug.
REQ-009 illegal_op, mem_err  output  1 each  single-cycle error pulses.

Function
REQ-010 State codes SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-011 Controls SHALL decode from state; any control not listed for a state SHALL be 0.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-014 MEMRD: MemRead=1, IorD=1. MEMWR: MemWrite=1, IorD=1. MEMWB: MemtoReg=1, RegWrite=1, RegDst=0.
REQ-015 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. ALUWB: RegDst=1, RegWrite=1. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. JUMP: PCWrite=1, PCSource=10.
REQ-017 FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0 and advance on the edge where mem_ready=1: FETCH->DECODE, MEMRD->MEMWB, MEMWR->FETCH.
REQ-018 DECODE transitions: opcode 0->EXEC, 35 or 43->MEMADR, 4->BRANCH, 8->ADDIEX, 2->JUMP (see REQ-026); any other->FETCH with illegal_op=1 for one cycle.
REQ-019 MEMADR SHALL go to MEMRD for opcode 35 and MEMWR for opcode 43, using the opcode captured in DECODE.
REQ-020 EXEC->ALUWB, ADDIEX->ADDIWB; ALUWB, MEMWB, ADDIWB, BRANCH and JUMP SHALL go to FETCH after one cycle.
REQ-021 Instruction latency SHALL be: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles with zero memory wait; each wait cycle adds one.
REQ-022 An 8-bit wait counter SHALL increment each cycle in FETCH, MEMRD or MEMWR with mem_ready=0 and SHALL clear on any state change.
REQ-023 When the counter equals MEM_TIMEOUT with mem_ready still 0, the block SHALL pulse mem_err for one cycle, suppress all writes (PCWrite, IRWrite, MemWrite, RegWrite = 0) that cycle, and go to FETCH; mem_ready=1 in that cycle SHALL win (normal advance, no mem_err).

Reset
REQ-024 rst_n=0 SHALL immediately force state=FETCH, wait counter=0, captured opcode=0, illegal_op=mem_err=0, independent of clk.
REQ-025 While rst_n=0, PCWrite and IRWrite SHALL be 0 regardless of mem_ready; after release, fetch begins on the first edge; reset mid-instruction SHALL abandon it without any register or memory write.

Configuration
REQ-026 Macro MC_JUMP_EN: defined -> opcode 2 in DECODE goes to JUMP; undefined -> JUMP state is unreachable, opcode 2 is illegal (illegal_op pulse, ->FETCH), and code 11 behaves as REQ-010 unused codes.

Verification
REQ-027 mem_ready=1 constant, opcode=0 -> states 0,1,6,7,0; RegDst=RegWrite=1 only in state 7.
REQ-028 opcode=35, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=IorD=1 throughout, then MEMWB with MemtoReg=RegWrite=1; total 8 cycles.
REQ-029 opcode=43 -> states 0,1,2,5,0; MemWrite=1 only in state 5; RegWrite never 1.
REQ-030 opcode=6'h3F in DECODE -> illegal_op=1 one cycle, next state 0; opcode=2 with/without MC_JUMP_EN -> JUMP with PCSource=10 / illegal_op pulse.
REQ-031 MEM_TIMEOUT=3, mem_ready held 0 in FETCH -> mem_err pulse on 4th FETCH cycle, PCWrite=IRWrite=0, counter restarts at 0.
REQ-032 rst_n low during MEMWR with mem_ready=1 -> state=0 asynchronously, MemWrite=0 before next edge.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout.
// Optional JUMP support is enabled by defining MC_JUMP_EN.
module mc_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

    state_t     state_q;
    logic [7:0] wait_q;
    logic [5:0] opc_q;
    state_t     dec_nxt;
    logic       dec_ill;
    logic       waiting;
    logic       timeout;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout = waiting && !mem_ready && (wait_q == TMO);

    always_comb begin
        dec_nxt = S_FETCH;
        dec_ill = 1'b0;
        case (opcode)
            OP_R:         dec_nxt = S_EXEC;
            OP_LW, OP_SW: dec_nxt = S_MEMADR;
            OP_BEQ:       dec_nxt = S_BRANCH;
            OP_ADDI:      dec_nxt = S_ADDIEX;
`ifdef MC_JUMP_EN
            OP_J:         dec_nxt = S_JUMP;
`endif
            default:      dec_ill = 1'b1;
        endcase
    end

    // Timeout has priority over the per-state transitions; mem_ready=1 already masks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            opc_q   <= '0;
        end else if (timeout) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            wait_q <= '0;
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE; else wait_q <= wait_q + 8'd1;
                S_DECODE: begin
                    opc_q   <= opcode;
                    state_q <= dec_nxt;
                end
                S_MEMADR: state_q <= (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB; else wait_q <= wait_q + 8'd1;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH; else wait_q <= wait_q + 8'd1;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:           ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB:           RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            default: ;
        endcase
        // Reset or an aborted access must never commit architectural state.
        if (!rst_n || timeout) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state      = state_q;
    assign illegal_op = (state_q == S_DECODE) && dec_ill;
    assign mem_err    = timeout;

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control, built with MEM_TIMEOUT=3.
module tb_mc_control;

    localparam int unsigned TMO = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;
    logic       illegal_op, mem_err;

    mc_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [17:0] obs_ctrl;
    assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, illegal_op, mem_err};

    // Reference control table written straight from the per-state control list.
    function automatic logic [17:0] model(int st, logic mr, logic ill, logic err, logic rst_ok);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, asa, rw, rd;
        logic [1:0] aop, asb, pcs;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, asa, rw, rd} = '0;
        aop = 2'b00; asb = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2, 9: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            10: rw = 1;
`ifdef MC_JUMP_EN
            11: begin pcw = 1; pcs = 2'b10; end
`endif
            default: ;
        endcase
        if (err || !rst_ok) begin pcw = 0; irw = 0; mwr = 0; rw = 0; end
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, asa, rw, rd, aop, asb, pcs, ill, err};
    endfunction

    task automatic expect_now(input int st, input logic ill, input logic err);
        exp_t e;
        e.st   = 4'(st);
        e.ctrl = model(st, mem_ready, ill, err, rst_n);
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        vectors += 2;
        assert (state === e.st) else begin
            miscompares++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, e.st);
        end
        assert (obs_ctrl === e.ctrl) else begin
            miscompares++;
            $error("FAIL %s ctrl: got %b expected %b", tag, obs_ctrl, e.ctrl);
        end
    endtask

    // One cycle: drive at negedge, check mid-cycle, advance to next negedge.
    task automatic cyc(input logic [5:0] op, input logic mr, input int st,
                       input logic ill, input logic err, input string tag);
        opcode    = op;
        mem_ready = mr;
        expect_now(st, ill, err);
        #2;
        check(tag);
        @(negedge clk);
    endtask

    logic j_ill;

    initial begin
`ifdef MC_JUMP_EN
        j_ill = 1'b0;
`else
        j_ill = 1'b1;
`endif
        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        #3;
        expect_now(0, 0, 0);
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // R-type: 0,1,6,7
        cyc(6'd0, 1, 0, 0, 0, "r_fetch");
        cyc(6'd0, 1, 1, 0, 0, "r_decode");
        cyc(6'd0, 1, 6, 0, 0, "r_exec");
        cyc(6'd0, 1, 7, 0, 0, "r_aluwb");
        // lw with 3 wait cycles; opcode changed after DECODE to exercise the captured copy
        cyc(6'd35, 1, 0, 0, 0, "lw_fetch");
        cyc(6'd35, 1, 1, 0, 0, "lw_decode");
        cyc(6'd0,  1, 2, 0, 0, "lw_memadr");
        cyc(6'd0,  0, 3, 0, 0, "lw_memrd_w0");
        cyc(6'd0,  0, 3, 0, 0, "lw_memrd_w1");
        cyc(6'd0,  0, 3, 0, 0, "lw_memrd_w2");
        cyc(6'd0,  1, 3, 0, 0, "lw_memrd_ready_at_limit");
        cyc(6'd0,  1, 4, 0, 0, "lw_memwb");
        // sw: 0,1,2,5
        cyc(6'd43, 1, 0, 0, 0, "sw_fetch");
        cyc(6'd43, 1, 1, 0, 0, "sw_decode");
        cyc(6'd43, 1, 2, 0, 0, "sw_memadr");
        cyc(6'd43, 1, 5, 0, 0, "sw_memwr");
        // beq and addi
        cyc(6'd4, 1, 0, 0, 0, "beq_fetch");
        cyc(6'd4, 1, 1, 0, 0, "beq_decode");
        cyc(6'd4, 1, 8, 0, 0, "beq_branch");
        cyc(6'd8, 1, 0, 0, 0, "addi_fetch");
        cyc(6'd8, 1, 1, 0, 0, "addi_decode");
        cyc(6'd8, 1, 9, 0, 0, "addi_ex");
        cyc(6'd8, 1, 10, 0, 0, "addi_wb");
        // illegal opcode
        cyc(6'h3F, 1, 0, 0, 0, "ill_fetch");
        cyc(6'h3F, 1, 1, 1, 0, "ill_decode");
        // jump / illegal depending on build
        cyc(6'd2, 1, 0, 0, 0, "j_fetch");
        cyc(6'd2, 1, 1, j_ill, 0, "j_decode");
`ifdef MC_JUMP_EN
        cyc(6'd2, 1, 11, 0, 0, "j_jump");
`endif
        // FETCH timeout: counter 0..3, error on the 4th cycle, then restart
        cyc(6'd0, 0, 0, 0, 0, "tmo_f0");
        cyc(6'd0, 0, 0, 0, 0, "tmo_f1");
        cyc(6'd0, 0, 0, 0, 0, "tmo_f2");
        cyc(6'd0, 0, 0, 0, 1, "tmo_f3_err");
        cyc(6'd0, 0, 0, 0, 0, "tmo_restart0");
        cyc(6'd0, 0, 0, 0, 0, "tmo_restart1");
        cyc(6'd0, 0, 0, 0, 0, "tmo_restart2");
        cyc(6'd0, 1, 0, 0, 0, "tmo_ready_wins");
        // MEMWR timeout suppresses the write
        cyc(6'd43, 1, 1, 0, 0, "swt_decode");
        cyc(6'd43, 1, 2, 0, 0, "swt_memadr");
        cyc(6'd43, 0, 5, 0, 0, "swt_w0");
        cyc(6'd43, 0, 5, 0, 0, "swt_w1");
        cyc(6'd43, 0, 5, 0, 0, "swt_w2");
        cyc(6'd43, 0, 5, 0, 1, "swt_err");
        // asynchronous reset during MEMWR with mem_ready high
        cyc(6'd43, 1, 0, 0, 0, "rst_fetch");
        cyc(6'd43, 1, 1, 0, 0, "rst_decode");
        cyc(6'd43, 1, 2, 0, 0, "rst_memadr");
        mem_ready = 1'b1;
        expect_now(5, 0, 0);
        #2;
        check("rst_memwr_pre");
        #1 rst_n = 1'b0;
        #1;
        expect_now(0, 0, 0);
        check("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(6'd0, 1, 0, 0, 0, "post_rst_fetch");
        cyc(6'd0, 1, 1, 0, 0, "post_rst_decode");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
